// File: rtl/uart_transmit.sv
// uart_transmit: double-buffered UART transmitter.
// Sends a start bit, 8 data bits LSB first, an optional parity bit and
// 1 or 2 stop bits. Each bit lasts `baudrate` clocks, with 0 treated as 1.
// Ports:
//   clk       system clock; all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   baudrate  clocks per bit; latched at the start of each frame
//   datain    byte to send; captured when wr=1 and thre=1
//   wr        write strobe
//   tx        serial line; registered and idle-high
//   thre      holding register empty
//   tsre      shifter empty; no frame in progress
//   done      one-cycle pulse on the last clock of a frame
//   over      one-cycle pulse after a write that arrived while thre=0
module uart_transmit #(
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] baudrate,
  input  logic [7:0] datain,
  input  logic       wr,
  output logic       tx,
  output logic       thre,
  output logic       tsre,
  output logic       done,
  output logic       over
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_INIT  = (PARITY_ODD != 0);
  localparam logic       ONE_STOP  = (STOP_BITS == 1);

  state_t     state;
  logic [7:0] holding;
  logic [7:0] shift;
  logic [7:0] b_lat;
  logic [7:0] cnt;
  logic [2:0] bitn;
  logic       par;
  logic       bit_end;
  logic       last_stop;
  logic       load;

  assign bit_end   = (cnt == b_lat - 8'd1);
  assign last_stop = (bitn == LAST_STOP);
  // A frame is loaded from IDLE or straight out of the final stop clock,
  // which gives back-to-back frames with no idle gap.
  assign load = !thre && ((state == IDLE) || (state == STOP && bit_end && last_stop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      holding <= '0;
      shift   <= '0;
      b_lat   <= 8'd1;
      cnt     <= '0;
      bitn    <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      thre    <= 1'b1;
      tsre    <= 1'b1;
      done    <= 1'b0;
      over    <= 1'b0;
    end else begin
      done <= 1'b0;
      over <= wr && !thre;

      if (wr && thre) begin
        holding <= datain;
        thre    <= 1'b0;
      end

      case (state)
        IDLE: tx <= 1'b1;

        START: begin
          if (bit_end) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= DATA;
            tx    <= shift[0];
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bitn == 3'd7) begin
              bitn <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= par;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
                done  <= ONE_STOP && (b_lat == 8'd1);
              end
            end else begin
              bitn <= bitn + 3'd1;
              tx   <= shift[1];
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= STOP;
            tx    <= 1'b1;
            done  <= ONE_STOP && (b_lat == 8'd1);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        STOP: begin
          // done is registered, so it is raised on the edge that enters
          // the final stop clock.
          if (bit_end) begin
            cnt <= '0;
            if (last_stop) begin
              state <= IDLE;
              tsre  <= 1'b1;
              tx    <= 1'b1;
            end else begin
              bitn <= bitn + 3'd1;
              done <= (b_lat == 8'd1) && ((bitn + 3'd1) == LAST_STOP);
            end
          end else begin
            cnt  <= cnt + 8'd1;
            done <= last_stop && ((cnt + 8'd1) == (b_lat - 8'd1));
          end
        end

        default: state <= IDLE;
      endcase

      // Frame load takes priority over the per-state updates above.
      if (load) begin
        shift <= holding;
        par   <= (^holding) ^ PAR_INIT;
        b_lat <= (baudrate == 8'd0) ? 8'd1 : baudrate;
        thre  <= 1'b1;
        tsre  <= 1'b0;
        state <= START;
        tx    <= 1'b0;
        cnt   <= '0;
        bitn  <= '0;
      end
    end
  end

endmodule
